// File: rtl/bch_scoreboard_pkg.sv
// Shared types and sizing helpers for the BCH result scoreboard.
package bch_scoreboard_pkg;

  localparam int DEF_CODE_BITS = 15;
  localparam int DEF_DATA_BITS = 7;
  localparam int DEF_ERR_SZ    = 2;

  typedef enum logic {
    COL_IDLE = 1'b0,
    COL_OPEN = 1'b1
  } col_state_e;

  // Stored entry layout, MSB first: {present, count, loc}.
  function automatic int entry_width(input int data_bits, input int err_sz);
    return 1 + err_sz + data_bits;
  endfunction

  function automatic int loc_beats(input int data_bits, input int bits);
    return (data_bits + bits - 1) / bits;
  endfunction

endpackage

// File: rtl/bch_scoreboard_loc_collector.sv
// Assembles BITS-wide error-location beats into DATA_BITS-wide words.
// state    | meaning
// COL_IDLE | no word open; non-first beats are ignored
// COL_OPEN | word started, beat_q is the next beat index
module bch_sb_loc_collector
  import bch_scoreboard_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int BITS      = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 loc_first_i,
  input  logic                 loc_valid_i,
  input  logic [BITS-1:0]      loc_data_i,
  input  logic                 start_ok_i,
  output logic                 word_done_o,
  output logic                 abandon_o,
  output logic [DATA_BITS-1:0] word_o
);

  localparam int NB = loc_beats(DATA_BITS, BITS);
  localparam int AW = NB * BITS;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  col_state_e    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [AW-1:0] asm_q, asm_d;
  logic          start, take;
  int            slot;

  assign start     = loc_valid_i && loc_first_i && start_ok_i;
  assign abandon_o = loc_valid_i && loc_first_i && (state_q == COL_OPEN);
  assign take      = start || (loc_valid_i && !loc_first_i && (state_q == COL_OPEN));
  assign word_o    = asm_d[DATA_BITS-1:0];

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    asm_d       = asm_q;
    word_done_o = 1'b0;
    slot        = 0;
    // A first beat always closes whatever was open, even if it cannot start a word.
    if (loc_valid_i && loc_first_i) state_d = COL_IDLE;
    if (take) begin
      slot = start ? 0 : int'(beat_q);
      asm_d[slot*BITS +: BITS] = loc_data_i;
      if (slot == NB - 1) begin
        word_done_o = 1'b1;
        state_d     = COL_IDLE;
        beat_d      = '0;
      end else begin
        state_d = COL_OPEN;
        beat_d  = BW'(slot + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= COL_IDLE;
      beat_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
    end
  end

endmodule

// File: rtl/bch_scoreboard.sv
// In-order checker of errors-present, error-count and error-location results
// against expected error vectors captured when each codeword enters the encoder.
module bch_scoreboard
  import bch_scoreboard_pkg::*;
#(
  parameter int CODE_BITS = DEF_CODE_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int ERR_SZ    = DEF_ERR_SZ,
  parameter int DEPTH     = 6,
  parameter int BITS      = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [CODE_BITS-1:0] exp_error,
  output logic                 push_ready,
  input  logic                 pres_valid,
  input  logic                 pres_in,
  input  logic                 cnt_valid,
  input  logic [ERR_SZ-1:0]    cnt_in,
  input  logic                 loc_first,
  input  logic                 loc_valid,
  input  logic [BITS-1:0]      loc_data,
  input  logic                 clear,
  output logic                 wrong,
  output logic                 fail_present,
  output logic                 fail_count,
  output logic                 fail_loc,
  output logic                 fail_overflow,
  output logic                 fail_underflow,
  output logic [15:0]          mismatch_count,
  output logic [15:0]          checked_count
);

  localparam int EW = entry_width(DATA_BITS, ERR_SZ);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_OCC = CW'(DEPTH);

  function automatic logic [ERR_SZ-1:0] popcount(input logic [CODE_BITS-1:0] v);
    logic [ERR_SZ-1:0] n;
    n = '0;
    for (int i = 0; i < CODE_BITS; i++) n = n + ERR_SZ'(v[i]);
    return n;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                         input logic [CW-1:0] c);
    logic [CW-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, pres_ptr_q, pres_ptr_d;
  logic [PW-1:0] cnt_ptr_q, cnt_ptr_d, loc_ptr_q, loc_ptr_d;
  logic [CW-1:0] pend_pres_q, pend_pres_d, pend_cnt_q, pend_cnt_d, pend_loc_q, pend_loc_d;
  logic          f_pres_q, f_pres_d, f_cnt_q, f_cnt_d, f_loc_q, f_loc_d;
  logic          f_ovf_q, f_ovf_d, f_unf_q, f_unf_d;
  logic [15:0]   mis_cnt_q, mis_cnt_d, chk_cnt_q, chk_cnt_d;

  logic [CW-1:0]        occ, occ_after;
  logic                 full, push_acc, pres_take, cnt_take, loc_take, retire;
  logic                 ev_ovf, ev_unf, ev_mis_p, ev_mis_c, ev_mis_l, any_event;
  logic                 start_ok, word_done, abandon;
  logic [DATA_BITS-1:0] loc_word;
  logic [EW-1:0]        new_entry, pres_ent, cnt_ent, loc_ent;

  bch_sb_loc_collector #(.DATA_BITS(DATA_BITS), .BITS(BITS)) u_collector (
    .clk         (clk),
    .reset_n     (reset_n),
    .loc_first_i (loc_first),
    .loc_valid_i (loc_valid),
    .loc_data_i  (loc_data),
    .start_ok_i  (start_ok),
    .word_done_o (word_done),
    .abandon_o   (abandon),
    .word_o      (loc_word)
  );

  // Occupancy is written minus retired, which equals the largest pending count.
  assign occ        = max3(pend_pres_q, pend_cnt_q, pend_loc_q);
  assign full       = (occ == FULL_OCC);
  assign push_ready = !full;
  assign push_acc   = push && !full;
  assign new_entry  = {|exp_error, popcount(exp_error), exp_error[DATA_BITS-1:0]};

  assign pres_ent = mem_q[pres_ptr_q];
  assign cnt_ent  = mem_q[cnt_ptr_q];
  assign loc_ent  = mem_q[loc_ptr_q];

  assign pres_take = pres_valid && (pend_pres_q != '0);
  assign cnt_take  = cnt_valid && (pend_cnt_q != '0);
  // An abandoned word consumes its entry, so the new word needs a second one.
  assign start_ok  = abandon ? (pend_loc_q > CW'(1)) : (pend_loc_q != '0);
  assign loc_take  = abandon || word_done;

  assign ev_ovf   = push && full;
  assign ev_unf   = (pres_valid && (pend_pres_q == '0)) || (cnt_valid && (pend_cnt_q == '0)) ||
                    (loc_valid && loc_first && !start_ok);
  assign ev_mis_p = pres_take && (pres_in != pres_ent[EW-1]);
  assign ev_mis_c = cnt_take && (cnt_in != cnt_ent[DATA_BITS +: ERR_SZ]);
  assign ev_mis_l = abandon || (word_done && (loc_word != loc_ent[DATA_BITS-1:0]));
  assign any_event = ev_ovf | ev_unf | ev_mis_p | ev_mis_c | ev_mis_l;

  assign occ_after = max3(pend_pres_q - CW'(pres_take), pend_cnt_q - CW'(cnt_take),
                          pend_loc_q - CW'(loc_take));
  assign retire    = (occ_after != occ);

  always_comb begin
    wr_ptr_d    = push_acc  ? ptr_inc(wr_ptr_q)   : wr_ptr_q;
    pres_ptr_d  = pres_take ? ptr_inc(pres_ptr_q) : pres_ptr_q;
    cnt_ptr_d   = cnt_take  ? ptr_inc(cnt_ptr_q)  : cnt_ptr_q;
    loc_ptr_d   = loc_take  ? ptr_inc(loc_ptr_q)  : loc_ptr_q;
    pend_pres_d = pend_pres_q + CW'(push_acc) - CW'(pres_take);
    pend_cnt_d  = pend_cnt_q + CW'(push_acc) - CW'(cnt_take);
    pend_loc_d  = pend_loc_q + CW'(push_acc) - CW'(loc_take);
    f_pres_d    = f_pres_q;
    f_cnt_d     = f_cnt_q;
    f_loc_d     = f_loc_q;
    f_ovf_d     = f_ovf_q;
    f_unf_d     = f_unf_q;
    mis_cnt_d   = mis_cnt_q;
    chk_cnt_d   = chk_cnt_q;
    if (clear) begin
      f_pres_d  = 1'b0;
      f_cnt_d   = 1'b0;
      f_loc_d   = 1'b0;
      f_ovf_d   = 1'b0;
      f_unf_d   = 1'b0;
      mis_cnt_d = '0;
      chk_cnt_d = '0;
    end else begin
      f_pres_d = f_pres_q | ev_mis_p;
      f_cnt_d  = f_cnt_q | ev_mis_c;
      f_loc_d  = f_loc_q | ev_mis_l;
      f_ovf_d  = f_ovf_q | ev_ovf;
      f_unf_d  = f_unf_q | ev_unf;
      if (any_event && (mis_cnt_q != 16'hFFFF)) mis_cnt_d = mis_cnt_q + 16'd1;
      if (retire && (chk_cnt_q != 16'hFFFF)) chk_cnt_d = chk_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      pres_ptr_q  <= '0;
      cnt_ptr_q   <= '0;
      loc_ptr_q   <= '0;
      pend_pres_q <= '0;
      pend_cnt_q  <= '0;
      pend_loc_q  <= '0;
      f_pres_q    <= 1'b0;
      f_cnt_q     <= 1'b0;
      f_loc_q     <= 1'b0;
      f_ovf_q     <= 1'b0;
      f_unf_q     <= 1'b0;
      mis_cnt_q   <= '0;
      chk_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      pres_ptr_q  <= pres_ptr_d;
      cnt_ptr_q   <= cnt_ptr_d;
      loc_ptr_q   <= loc_ptr_d;
      pend_pres_q <= pend_pres_d;
      pend_cnt_q  <= pend_cnt_d;
      pend_loc_q  <= pend_loc_d;
      f_pres_q    <= f_pres_d;
      f_cnt_q     <= f_cnt_d;
      f_loc_q     <= f_loc_d;
      f_ovf_q     <= f_ovf_d;
      f_unf_q     <= f_unf_d;
      mis_cnt_q   <= mis_cnt_d;
      chk_cnt_q   <= chk_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push_acc) mem_q[wr_ptr_q] <= new_entry;
  end

  assign fail_present   = f_pres_q;
  assign fail_count     = f_cnt_q;
  assign fail_loc       = f_loc_q;
  assign fail_overflow  = f_ovf_q;
  assign fail_underflow = f_unf_q;
  assign wrong          = f_pres_q | f_cnt_q | f_loc_q | f_ovf_q | f_unf_q;
  assign mismatch_count = mis_cnt_q;
  assign checked_count  = chk_cnt_q;

endmodule

// File: doc/bch_scoreboard.md
# bch_scoreboard

Synthesizable, parametrised in-order result checker for the BCH encode → syndrome → key → error-locate chain. Expected error vectors are pushed when a codeword enters the encoder. Three independent result streams are checked against them in order: errors-present, error count, and the serial or BITS-wide error-location stream. Mismatch, overflow and underflow are reported as sticky flags plus saturating counters. It replaces ad-hoc simulation stacks and can sit in hardware test builds.

## Interface
- P, `BCH_SANE, BCH parameter vector; gives N, B = `BCH_DATA_BITS(P), C = `BCH_CODE_BITS(P), `BCH_ERR_SZ(P)
- DEPTH, 6, expected-entry FIFO depth; any integer ≥ 2, not required to be a power of two
- BITS, 1, error-location bits per beat, 1..B
- clk  in  1  sole clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- push  in  1  capture one expected entry from exp_error
- exp_error  in  C  injected error vector for the codeword just started
- push_ready  out  1  high when FIFO not full
- pres_valid  in  1  errors-present result strobe
- pres_in  in  1  DUT errors_present
- cnt_valid  in  1  error-count result strobe
- cnt_in  in  `BCH_ERR_SZ(P)  DUT err_count
- loc_first  in  1  first beat of a location word; only meaningful with loc_valid
- loc_valid  in  1  location beat valid
- loc_data  in  BITS  location bits for this beat
- clear  in  1  clear flags and counters; FIFO untouched
- wrong  out  1  OR of all fail_* flags
- fail_present, fail_count, fail_loc, fail_overflow, fail_underflow  out  1 each  sticky flags
- mismatch_count  out  16  saturating count of mismatch events of any kind
- checked_count  out  16  saturating count of fully retired entries

## Operation
- Entry stored on push:
  - present = |exp_error
  - count = popcount(exp_error) over all C bits, truncated to `BCH_ERR_SZ(P)
  - loc = exp_error[B-1:0]
- One write pointer and three read pointers (pres, cnt, loc). All wrap modulo DEPTH.
- Each reader keeps a pending counter, width log2(DEPTH+1), equal to entries written but not yet consumed by that reader.
- An entry retires when all three readers have consumed it. Occupancy = written − retired; full when occupancy == DEPTH.
- Push while full: entry dropped, fail_overflow set.
- pres_valid or cnt_valid with that reader's pending == 0: fail_underflow set, no compare, pointer holds. Same rule for a loc_first beat.
- Otherwise the result is compared with the entry; any mismatch sets the matching fail_* flag and the pointer advances.
- Location collector:
  - A beat with loc_first starts a word at beat 0.
  - Beat k supplies bits [k*BITS +: BITS]. Bits at index ≥ B in the last beat are ignored.
  - The word completes after ceil(B/BITS) beats, then is compared with entry.loc.
  - loc_valid without loc_first when no word is open: ignored.
  - loc_first while a word is open: the open word counts as a fail_loc mismatch and its entry is consumed. The new beat then starts the next word, and the underflow check applies to it.
- mismatch_count increments once per cycle if any new mismatch, overflow or underflow event occurs; it saturates at 16'hFFFF. checked_count increments per retirement and also saturates.
- Precedence: clear beats new events in the same cycle. reset_n beats clear.

## Timing
- Reset (reset_n low at an edge): all pointers, pending counters, collector, flags and counters go to 0; push_ready = 1 the next cycle. Inputs are ignored during reset; reset mid-word discards the word.
- push_ready = !full, combinational from registered state. A retirement frees its slot from the next cycle; a push in the retirement cycle still sees full.
- Push and any result in the same cycle are allowed. A push becomes visible to readers the next cycle, so a result arriving in the same cycle as the push for an empty FIFO underflows.
- Compare is combinational on the strobe cycle. Flags, counters and wrong update at the following edge (1-cycle latency).
- All three readers may consume in the same cycle. Retirement is evaluated on post-advance pointers.

## Structure
- Add to bch_defs.vh: macro for entry width (1 + `BCH_ERR_SZ(P) + B); take log2 from bch.vh.
- Sub-module bch_sb_loc_collector: beat counter, shift/assemble register, word_done and abandon outputs.
- Popcount is a function in the top module.

## Test plan
- DEPTH=4, BITS=1. Push exp_error=0; pres_in=0, cnt_in=0, B zero beats → checked_count=1, wrong=0.
- Push exp_error with bit 3 set. Send pres_in=1, cnt_in=1, and a location word with only beat 3 =1 → no flags. Repeat with cnt_in=2 → fail_count=1, mismatch_count=1 one cycle after the strobe.
- Five pushes with no results at DEPTH=4 → push_ready=0 after the 4th; the 5th sets fail_overflow. Retire one entry → push_ready=1 on the next cycle.
- cnt_valid after reset with no push → fail_underflow=1, cnt pointer unchanged. A later push followed by the correct count → no fail_count.
- BITS=4: loc_first before a word completes → fail_loc=1 and the entry is consumed; the next full word checks the next entry correctly.
- mismatch_count forced to 16'hFFFF by repeated fail_count events stays saturated. clear then gives 0 and wrong=0, and FIFO occupancy is unchanged; reset_n low mid-stream gives all outputs 0 and push_ready=1.
